// File: rtl/niski_pkg.sv
// Shared types, LCD command constants and display helpers for the Niski demo.
package niski_pkg;

    localparam int unsigned TIMER_W    = 24;
    localparam int unsigned LCD_ITEMS  = 9;
    localparam int unsigned ITEM_IDX_W = 4;
    localparam int unsigned COUNT_W    = 16;

    localparam logic [7:0] LCD_FUNCTION_SET = 8'h38;
    localparam logic [7:0] LCD_DISPLAY_ON   = 8'h0C;
    localparam logic [7:0] LCD_ENTRY_MODE   = 8'h06;
    localparam logic [7:0] LCD_CLEAR        = 8'h01;

    typedef enum logic [2:0] {
        LCD_POWERUP,
        LCD_SETUP,
        LCD_PULSE,
        LCD_WAIT,
        LCD_DONE
    } lcd_state_t;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_item_t;

    // Init commands followed by the text "Niski".
    function automatic lcd_item_t lcd_rom(input logic [ITEM_IDX_W-1:0] idx);
        lcd_item_t item;
        item.rs   = 1'b1;
        item.data = 8'h00;
        case (idx)
            4'd0:    begin item.rs = 1'b0; item.data = LCD_FUNCTION_SET; end
            4'd1:    begin item.rs = 1'b0; item.data = LCD_DISPLAY_ON;   end
            4'd2:    begin item.rs = 1'b0; item.data = LCD_ENTRY_MODE;   end
            4'd3:    begin item.rs = 1'b0; item.data = LCD_CLEAR;        end
            4'd4:    item.data = 8'h4E;
            4'd5:    item.data = 8'h69;
            4'd6:    item.data = 8'h73;
            4'd7:    item.data = 8'h6B;
            4'd8:    item.data = 8'h69;
            default: begin item.rs = 1'b0; item.data = 8'h00; end
        endcase
        return item;
    endfunction

    // Hex nibble to active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/niski_lcd_seq.sv
// HD44780 8-bit write sequencer: power-up delay, init commands, then "Niski".
module niski_lcd_seq
    import niski_pkg::*;
#(
    parameter int unsigned LCD_POWERUP_CYCLES    = 2500,
    parameter int unsigned LCD_E_CYCLES          = 12,
    parameter int unsigned LCD_WAIT_CYCLES       = 1250,
    parameter int unsigned LCD_CLEAR_WAIT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst,
    output logic       rs,
    output logic       e,
    output logic [7:0] data
);

    localparam logic [TIMER_W-1:0]    POWERUP_LAST = TIMER_W'(LCD_POWERUP_CYCLES - 1);
    localparam logic [TIMER_W-1:0]    E_LAST       = TIMER_W'(LCD_E_CYCLES - 1);
    localparam logic [TIMER_W-1:0]    WAIT_LAST    = TIMER_W'(LCD_WAIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0]    CLEAR_LAST   = TIMER_W'(LCD_CLEAR_WAIT_CYCLES - 1);
    localparam logic [ITEM_IDX_W-1:0] LAST_IDX     = ITEM_IDX_W'(LCD_ITEMS - 1);

    lcd_state_t            state = LCD_POWERUP;
    lcd_state_t            state_d;
    logic [TIMER_W-1:0]    timer = '0;
    logic [TIMER_W-1:0]    timer_d;
    logic [ITEM_IDX_W-1:0] idx = '0;
    logic [ITEM_IDX_W-1:0] idx_d;
    logic                  rs_q = 1'b0;
    logic                  e_q = 1'b0;
    logic [7:0]            data_q = 8'h00;
    logic                  rs_d;
    logic                  e_d;
    logic [7:0]            data_d;
    logic [TIMER_W-1:0]    wait_last;
    lcd_item_t             item;

    // The clear command needs a much longer settle time than the others.
    assign wait_last = (!rs_q && (data_q == LCD_CLEAR)) ? CLEAR_LAST : WAIT_LAST;

    // State, timers and registered pin values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= LCD_POWERUP;
            timer  <= '0;
            idx    <= '0;
            rs_q   <= 1'b0;
            e_q    <= 1'b0;
            data_q <= 8'h00;
        end else begin
            state  <= state_d;
            timer  <= timer_d;
            idx    <= idx_d;
            rs_q   <= rs_d;
            e_q    <= e_d;
            data_q <= data_d;
        end
    end

    // Next-state, timer and item index.
    always_comb begin
        state_d = state;
        timer_d = timer + TIMER_W'(1);
        idx_d   = idx;
        case (state)
            LCD_POWERUP: begin
                if (timer == POWERUP_LAST) begin
                    state_d = LCD_SETUP;
                    timer_d = '0;
                end
            end
            LCD_SETUP: begin
                state_d = LCD_PULSE;
                timer_d = '0;
            end
            LCD_PULSE: begin
                if (timer == E_LAST) begin
                    state_d = LCD_WAIT;
                    timer_d = '0;
                end
            end
            LCD_WAIT: begin
                if (timer == wait_last) begin
                    timer_d = '0;
                    if (idx == LAST_IDX) begin
                        state_d = LCD_DONE;
                    end else begin
                        state_d = LCD_SETUP;
                        idx_d   = idx + ITEM_IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = LCD_DONE;
                timer_d = timer;
            end
        endcase
    end

    // Next pin values: bus loads on entry to SETUP, E follows PULSE.
    always_comb begin
        item   = lcd_rom(idx_d);
        rs_d   = rs_q;
        data_d = data_q;
        e_d    = (state_d == LCD_PULSE);
        if (state_d == LCD_SETUP) begin
            rs_d   = item.rs;
            data_d = item.data;
        end
    end

    assign rs   = rs_q;
    assign e    = e_q;
    assign data = data_q;

endmodule

// File: rtl/niski_dut.sv
// Niski board top: button sync, press counter, 7-seg mux, LEDs and LCD writer.
module niski_dut
    import niski_pkg::*;
#(
    parameter int unsigned LCD_POWERUP_CYCLES    = 2500,
    parameter int unsigned LCD_E_CYCLES          = 12,
    parameter int unsigned LCD_WAIT_CYCLES       = 1250,
    parameter int unsigned LCD_CLEAR_WAIT_CYCLES = 5000,
    parameter int unsigned REFRESH_CYCLES        = 256
) (
    input  logic       CLK_PIN,
    input  logic [4:0] BTN_PINS,
    output logic [3:0] LED_PINS,
    output logic [6:0] SEVSEG_SEG_PINS,
    output logic [3:0] SEVSEG_SEL_PINS,
    output logic       LCD_RS_PIN,
    output logic       LCD_RW_PIN,
    output logic       LCD_E_PIN,
    output logic [7:0] LCD_DATA_PINS
);

    localparam int unsigned REFRESH_W = $clog2(REFRESH_CYCLES + 1);
    localparam logic [REFRESH_W-1:0] REFRESH_LAST = REFRESH_W'(REFRESH_CYCLES - 1);

    logic                 clk;
    logic                 rst;
    logic [3:0]           btn_meta = '0;
    logic [3:0]           btn_sync = '0;
    logic                 btn0_prev = 1'b0;
    logic [3:0]           led_q = '0;
    logic [COUNT_W-1:0]   press_count = '0;
    logic [REFRESH_W-1:0] refresh_cnt = '0;
    logic [1:0]           digit = '0;
    logic [3:0]           sel_q = 4'b1110;
    logic [6:0]           seg_q = 7'h40;
    logic [3:0]           nibble;

    assign clk = CLK_PIN;
    assign rst = ~BTN_PINS[4];

    // Two-flop synchroniser, LED mirror and press counter on BTN[0] rising.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta    <= '0;
            btn_sync    <= '0;
            btn0_prev   <= 1'b0;
            led_q       <= '0;
            press_count <= '0;
        end else begin
            btn_meta  <= BTN_PINS[3:0];
            btn_sync  <= btn_meta;
            btn0_prev <= btn_sync[0];
            led_q     <= btn_sync;
            if (btn_sync[0] && !btn0_prev) begin
                press_count <= press_count + COUNT_W'(1);
            end
        end
    end

    assign nibble = 4'(press_count >> {digit, 2'b00});

    // Digit scan: dwell REFRESH_CYCLES per digit and register SEL/SEG.
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit       <= '0;
            sel_q       <= 4'b1110;
            seg_q       <= 7'h40;
        end else begin
            if (refresh_cnt == REFRESH_LAST) begin
                refresh_cnt <= '0;
                digit       <= digit + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + REFRESH_W'(1);
            end
            sel_q <= ~(4'b0001 << digit);
            seg_q <= hex_to_seg(nibble);
        end
    end

    niski_lcd_seq #(
        .LCD_POWERUP_CYCLES   (LCD_POWERUP_CYCLES),
        .LCD_E_CYCLES         (LCD_E_CYCLES),
        .LCD_WAIT_CYCLES      (LCD_WAIT_CYCLES),
        .LCD_CLEAR_WAIT_CYCLES(LCD_CLEAR_WAIT_CYCLES)
    ) u_lcd_seq (
        .clk (clk),
        .rst (rst),
        .rs  (LCD_RS_PIN),
        .e   (LCD_E_PIN),
        .data(LCD_DATA_PINS)
    );

    assign LCD_RW_PIN      = 1'b0;
    assign LED_PINS        = led_q;
    assign SEVSEG_SEL_PINS = sel_q;
    assign SEVSEG_SEG_PINS = seg_q;

endmodule

// File: tb/tb_niski_dut.sv
// Directed bench for niski_dut: power-on, LCD write sequence, reset, buttons, display.
module tb_niski_dut;

    logic       clk = 1'b0;
    logic [4:0] btn = 5'b00000;
    logic [3:0] led;
    logic [6:0] seg;
    logic [3:0] sel;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data;

    int         checks = 0;
    int         errors = 0;
    int         n = 0;
    logic       prev_rs = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       rw_bad = 1'b0;

    int         exp_rise [9];
    logic [7:0] exp_data [9];
    logic       exp_rs   [9];

    niski_dut dut (
        .CLK_PIN        (clk),
        .BTN_PINS       (btn),
        .LED_PINS       (led),
        .SEVSEG_SEG_PINS(seg),
        .SEVSEG_SEL_PINS(sel),
        .LCD_RS_PIN     (lcd_rs),
        .LCD_RW_PIN     (lcd_rw),
        .LCD_E_PIN      (lcd_e),
        .LCD_DATA_PINS  (lcd_data)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge, remembering the bus seen one cycle earlier.
    task automatic step();
        prev_data = lcd_data;
        prev_rs   = lcd_rs;
        @(negedge clk);
        n++;
        if (lcd_rw !== 1'b0) rw_bad = 1'b1;
    endtask

    task automatic press();
        btn[0] = 1'b1;
        repeat (3) step();
        btn[0] = 1'b0;
        repeat (3) step();
    endtask

    task automatic wait_sel(input logic [3:0] pat);
        int k;
        k = 0;
        while (sel !== pat && k < 1100) begin
            step();
            k++;
        end
    endtask

    task automatic wait_rise(input int limit);
        while (lcd_e !== 1'b1 && n < limit) step();
    endtask

    initial begin
        int         hi;
        logic       stable;
        logic [8:0] held;
        int         e_after;

        exp_rise = '{2501, 3764, 5027, 6290, 11303, 12566, 13829, 15092, 16355};
        exp_data = '{8'h38, 8'h0C, 8'h06, 8'h01, 8'h4E, 8'h69, 8'h73, 8'h6B, 8'h69};
        exp_rs   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        // Short reset glitch with no clock edge: power-on values must hold.
        #2 btn[4] = 1'b1;
        #3;
        chk("pwron_e", 32'(lcd_e), 32'h0);
        chk("pwron_sel", 32'(sel), 32'hE);
        chk("pwron_seg", 32'(seg), 32'h40);
        chk("pwron_led", 32'(led), 32'h0);
        chk("pwron_data", 32'({lcd_rs, lcd_data}), 32'h0);

        // Clean two-cycle reset, then count cycles from release.
        @(negedge clk);
        btn[4] = 1'b0;
        step();
        step();
        btn[4] = 1'b1;
        n = 0;

        for (int i = 0; i < 9; i++) begin
            wait_rise(exp_rise[i] + 20);
            chk("e_rise_cycle", 32'(n), 32'(exp_rise[i]));
            chk("item_data", 32'(lcd_data), 32'(exp_data[i]));
            chk("item_rs", 32'(lcd_rs), 32'(exp_rs[i]));
            chk("setup_before_e", 32'({prev_rs, prev_data}), 32'({lcd_rs, lcd_data}));
            held   = {lcd_rs, lcd_data};
            hi     = 0;
            stable = 1'b1;
            while (lcd_e === 1'b1 && hi < 40) begin
                if ({lcd_rs, lcd_data} !== held) stable = 1'b0;
                hi++;
                step();
            end
            chk("e_width", 32'(hi), 32'd12);
            chk("hold_in_pulse", 32'(stable), 32'h1);
            chk("hold_after_fall", 32'({lcd_rs, lcd_data}), 32'(held));
        end

        e_after = 0;
        while (n < 25000) begin
            step();
            if (lcd_e !== 1'b0) e_after++;
        end
        chk("no_e_after_done", 32'(e_after), 32'h0);
        chk("done_bus", 32'({lcd_rs, lcd_data}), 32'h169);
        chk("rw_low", 32'(rw_bad), 32'h0);

        // Fresh run, reset while E is high during the second write.
        btn[4] = 1'b0;
        step();
        step();
        btn[4] = 1'b1;
        n = 0;
        wait_rise(exp_rise[0] + 20);
        repeat (13) step();
        wait_rise(exp_rise[1] + 20);
        chk("second_rise_cycle", 32'(n), 32'(exp_rise[1]));
        repeat (3) step();
        chk("e_high_mid", 32'(lcd_e), 32'h1);
        btn[4] = 1'b0;
        step();
        chk("reset_e_low", 32'(lcd_e), 32'h0);
        chk("reset_bus", 32'({lcd_rs, lcd_data}), 32'h0);
        step();
        btn[4] = 1'b1;
        n = 0;
        wait_rise(exp_rise[0] + 20);
        chk("restart_rise_cycle", 32'(n), 32'(exp_rise[0]));
        chk("restart_data", 32'({lcd_rs, lcd_data}), 32'h038);

        // LED latency on BTN[0], also the first press.
        btn[0] = 1'b1;
        step();
        step();
        chk("led_lat2", 32'(led), 32'h0);
        step();
        chk("led_lat3", 32'(led), 32'h1);
        btn[0] = 1'b0;
        repeat (3) step();
        press();
        press();

        wait_sel(4'b1110);
        chk("sel_d0", 32'(sel), 32'hE);
        chk("seg_d0_cnt3", 32'(seg), 32'h30);
        wait_sel(4'b1101);
        chk("seg_d1_cnt3", 32'(seg), 32'h40);
        wait_sel(4'b1011);
        chk("seg_d2_cnt3", 32'(seg), 32'h40);
        wait_sel(4'b0111);
        chk("seg_d3_cnt3", 32'(seg), 32'h40);

        // BTN[2:1] only drive LEDs, not the counter.
        btn[2:1] = 2'b11;
        step();
        step();
        chk("led21_lat2", 32'(led), 32'h0);
        step();
        chk("led21_lat3", 32'(led), 32'h6);
        wait_sel(4'b1110);
        chk("seg_d0_unchanged", 32'(seg), 32'h30);
        btn[2:1] = 2'b00;
        repeat (3) step();

        // Fifteen more presses: count 0x0012.
        for (int p = 0; p < 15; p++) press();
        wait_sel(4'b1110);
        chk("seg_d0_cnt12", 32'(seg), 32'h24);
        wait_sel(4'b1101);
        chk("seg_d1_cnt12", 32'(seg), 32'h79);
        wait_sel(4'b1011);
        chk("seg_d2_cnt12", 32'(seg), 32'h40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
